// File: rtl/rs_station_pkg.sv
// Shared types and CDB match helper for the reservation station.
package rs_pkg;
    localparam int RS_W   = 4;
    localparam int ROB_W  = 5;
    localparam int OP_W   = 8;
    localparam int N_CDB  = 2;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [ROB_W-1:0]  dest;
        logic [ROB_W-1:0]  q1;
        logic [ROB_W-1:0]  q2;
        logic              r1;
        logic              r2;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
    } rs_entry_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] value;
    } cdb_hit_t;

    // Lowest channel index wins when several channels carry the same tag.
    function automatic cdb_hit_t cdb_match(
        input logic [ROB_W-1:0]        tag,
        input logic [N_CDB-1:0]        valid,
        input logic [N_CDB*ROB_W-1:0]  tags,
        input logic [N_CDB*DATA_W-1:0] values
    );
        cdb_hit_t res;
        res = '0;
        for (int unsigned k = 0; k < N_CDB; k++) begin
            if (!res.hit && valid[k] && (tags[k*ROB_W +: ROB_W] == tag)) begin
                res.hit   = 1'b1;
                res.value = values[k*DATA_W +: DATA_W];
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/rs_station_pick.sv
// Lowest-index priority encoder.
module rs_pick #(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     req,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] index
);
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                index = IDX_WIDTH'(i);
            end
        end
    end
endmodule

// File: rtl/rs_station.sv
// Reservation station: issue with CDB bypass, CDB snoop, and a registered
// valid/ready dispatch port feeding one execution unit.
module rs_station
    import rs_pkg::*;
#(
    parameter int RS_WIDTH   = RS_W,
    parameter int ROB_WIDTH  = ROB_W,
    parameter int OP_WIDTH   = OP_W,
    parameter int NUM_CDB    = N_CDB,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          rdy_in,
    input  logic                          flush_in,
    input  logic                          issue_valid_in,
    input  logic [OP_WIDTH-1:0]           issue_op_in,
    input  logic [ROB_WIDTH-1:0]          issue_dest_in,
    input  logic [ROB_WIDTH-1:0]          issue_q1_in,
    input  logic [ROB_WIDTH-1:0]          issue_q2_in,
    input  logic                          issue_r1_in,
    input  logic                          issue_r2_in,
    input  logic [DATA_WIDTH-1:0]         issue_v1_in,
    input  logic [DATA_WIDTH-1:0]         issue_v2_in,
    input  logic [NUM_CDB-1:0]            cdb_valid_in,
    input  logic [NUM_CDB*ROB_WIDTH-1:0]  cdb_tag_in,
    input  logic [NUM_CDB*DATA_WIDTH-1:0] cdb_value_in,
    output logic                          full_out,
    output logic [RS_WIDTH:0]             count_out,
    output logic                          disp_valid_out,
    input  logic                          disp_ready_in,
    output logic [OP_WIDTH-1:0]           disp_op_out,
    output logic [ROB_WIDTH-1:0]          disp_dest_out,
    output logic [DATA_WIDTH-1:0]         disp_v1_out,
    output logic [DATA_WIDTH-1:0]         disp_v2_out
);
    localparam int DEPTH = 2**RS_WIDTH;
    localparam int CW    = RS_WIDTH + 1;

    rs_entry_t ent   [DEPTH];
    rs_entry_t snoop [DEPTH];
    rs_entry_t new_ent;

    logic [DEPTH-1:0]    busy_vec, free_vec, ready_vec;
    logic                free_found, ready_found;
    logic [RS_WIDTH-1:0] free_idx, ready_idx;
    logic                issue_acc, disp_load;
    cdb_hit_t            bp1, bp2;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy && ent[i].r1 && ent[i].r2;
        end
        free_vec = ~busy_vec;
    end

    rs_pick #(.WIDTH(DEPTH), .IDX_WIDTH(RS_WIDTH)) free_pick (
        .req(free_vec), .found(free_found), .index(free_idx)
    );

    rs_pick #(.WIDTH(DEPTH), .IDX_WIDTH(RS_WIDTH)) ready_pick (
        .req(ready_vec), .found(ready_found), .index(ready_idx)
    );

    assign full_out  = (count_out == CW'(DEPTH));
    assign issue_acc = issue_valid_in && !full_out && free_found;
    assign disp_load = (!disp_valid_out || disp_ready_in) && ready_found;

    always_comb begin
        bp1 = cdb_match(issue_q1_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
        bp2 = cdb_match(issue_q2_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
        new_ent      = '0;
        new_ent.busy = 1'b1;
        new_ent.op   = issue_op_in;
        new_ent.dest = issue_dest_in;
        new_ent.q1   = issue_q1_in;
        new_ent.q2   = issue_q2_in;
        new_ent.r1   = issue_r1_in || bp1.hit;
        new_ent.r2   = issue_r2_in || bp2.hit;
        new_ent.v1   = issue_r1_in ? issue_v1_in : bp1.value;
        new_ent.v2   = issue_r2_in ? issue_v2_in : bp2.value;
    end

    always_comb begin
        cdb_hit_t s1, s2;
        s1 = '0;
        s2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            snoop[i] = ent[i];
            s1 = cdb_match(ent[i].q1, cdb_valid_in, cdb_tag_in, cdb_value_in);
            s2 = cdb_match(ent[i].q2, cdb_valid_in, cdb_tag_in, cdb_value_in);
            if (ent[i].busy && !ent[i].r1 && s1.hit) begin
                snoop[i].r1 = 1'b1;
                snoop[i].v1 = s1.value;
            end
            if (ent[i].busy && !ent[i].r2 && s2.hit) begin
                snoop[i].r2 = 1'b1;
                snoop[i].v2 = s2.value;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
            disp_valid_out <= 1'b0;
            disp_op_out    <= '0;
            disp_dest_out  <= '0;
            disp_v1_out    <= '0;
            disp_v2_out    <= '0;
            count_out      <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                for (int unsigned i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
                disp_valid_out <= 1'b0;
                disp_op_out    <= '0;
                disp_dest_out  <= '0;
                disp_v1_out    <= '0;
                disp_v2_out    <= '0;
                count_out      <= '0;
            end else begin
                // Dispatched entry is ready (never snooped) and the issue slot
                // was free, so these later writes never collide with each other.
                for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= snoop[i];
                if (disp_load) begin
                    ent[ready_idx].busy <= 1'b0;
                    disp_valid_out      <= 1'b1;
                    disp_op_out         <= ent[ready_idx].op;
                    disp_dest_out       <= ent[ready_idx].dest;
                    disp_v1_out         <= ent[ready_idx].v1;
                    disp_v2_out         <= ent[ready_idx].v2;
                end else if (disp_ready_in) begin
                    disp_valid_out <= 1'b0;
                end
                if (issue_acc) ent[free_idx] <= new_ent;
                count_out <= count_out + CW'(issue_acc) - CW'(disp_load);
            end
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// Randomized and directed bench for rs_station against a slot-array model.
module tb_rs_station;
    localparam int N = 16;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in, flush_in;
    logic        issue_valid_in;
    logic [7:0]  issue_op_in;
    logic [4:0]  issue_dest_in, issue_q1_in, issue_q2_in;
    logic        issue_r1_in, issue_r2_in;
    logic [31:0] issue_v1_in, issue_v2_in;
    logic [1:0]  cdb_valid_in;
    logic [9:0]  cdb_tag_in;
    logic [63:0] cdb_value_in;
    logic        full_out;
    logic [4:0]  count_out;
    logic        disp_valid_out, disp_ready_in;
    logic [7:0]  disp_op_out;
    logic [4:0]  disp_dest_out;
    logic [31:0] disp_v1_out, disp_v2_out;

    logic        c_valid [2];
    logic [4:0]  c_tag   [2];
    logic [31:0] c_val   [2];

    logic        m_busy [N];
    logic [7:0]  m_op   [N];
    logic [4:0]  m_dest [N], m_q1 [N], m_q2 [N];
    logic        m_r1   [N], m_r2 [N];
    logic [31:0] m_v1   [N], m_v2 [N];
    logic        m_dv;
    logic [7:0]  m_dop;
    logic [4:0]  m_ddest;
    logic [31:0] m_dv1, m_dv2;

    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cdb_valid_in[k]          = c_valid[k];
            cdb_tag_in[k*5 +: 5]     = c_tag[k];
            cdb_value_in[k*32 +: 32] = c_val[k];
        end
    end

    rs_station #(
        .RS_WIDTH(4), .ROB_WIDTH(5), .OP_WIDTH(8), .NUM_CDB(2), .DATA_WIDTH(32)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .issue_valid_in(issue_valid_in), .issue_op_in(issue_op_in),
        .issue_dest_in(issue_dest_in), .issue_q1_in(issue_q1_in), .issue_q2_in(issue_q2_in),
        .issue_r1_in(issue_r1_in), .issue_r2_in(issue_r2_in),
        .issue_v1_in(issue_v1_in), .issue_v2_in(issue_v2_in),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
        .full_out(full_out), .count_out(count_out),
        .disp_valid_out(disp_valid_out), .disp_ready_in(disp_ready_in),
        .disp_op_out(disp_op_out), .disp_dest_out(disp_dest_out),
        .disp_v1_out(disp_v1_out), .disp_v2_out(disp_v2_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic logic bcast(input logic [4:0] tag, output logic [31:0] val);
        val = '0;
        for (int k = 0; k < 2; k++) begin
            if (c_valid[k] && c_tag[k] == tag) begin
                val = c_val[k];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_dv = 1'b0; m_dop = '0; m_ddest = '0; m_dv1 = '0; m_dv2 = '0;
    endtask

    task automatic model_step();
        int fi, ri;
        logic [31:0] hv;
        if (!rdy_in) return;
        if (flush_in) begin
            model_reset();
            return;
        end
        fi = -1;
        ri = -1;
        for (int i = 0; i < N; i++) begin
            if (fi < 0 && !m_busy[i]) fi = i;
            if (ri < 0 && m_busy[i] && m_r1[i] && m_r2[i]) ri = i;
        end
        if ((!m_dv || disp_ready_in) && ri >= 0) begin
            m_dv = 1'b1; m_dop = m_op[ri]; m_ddest = m_dest[ri];
            m_dv1 = m_v1[ri]; m_dv2 = m_v2[ri];
            m_busy[ri] = 1'b0;
        end else if (disp_ready_in) begin
            m_dv = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && !m_r1[i] && bcast(m_q1[i], hv)) begin m_r1[i] = 1'b1; m_v1[i] = hv; end
            if (m_busy[i] && !m_r2[i] && bcast(m_q2[i], hv)) begin m_r2[i] = 1'b1; m_v2[i] = hv; end
        end
        if (issue_valid_in && fi >= 0) begin
            m_busy[fi] = 1'b1; m_op[fi] = issue_op_in; m_dest[fi] = issue_dest_in;
            m_q1[fi] = issue_q1_in; m_q2[fi] = issue_q2_in;
            m_r1[fi] = issue_r1_in; m_v1[fi] = issue_v1_in;
            m_r2[fi] = issue_r2_in; m_v2[fi] = issue_v2_in;
            if (!issue_r1_in && bcast(issue_q1_in, hv)) begin m_r1[fi] = 1'b1; m_v1[fi] = hv; end
            if (!issue_r2_in && bcast(issue_q2_in, hv)) begin m_r2[fi] = 1'b1; m_v2[fi] = hv; end
        end
    endtask

    task automatic check_outputs();
        check_eq("count", count_out, m_count());
        check_eq("full", full_out, m_count() == N);
        check_eq("disp_valid", disp_valid_out, m_dv);
        if (m_dv) begin
            check_eq("disp_op", disp_op_out, m_dop);
            check_eq("disp_dest", disp_dest_out, m_ddest);
            check_eq("disp_v1", disp_v1_out, m_dv1);
            check_eq("disp_v2", disp_v2_out, m_dv2);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk_in);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        rdy_in = 1'b1; flush_in = 1'b0; issue_valid_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            c_valid[k] = 1'b0; c_tag[k] = '0; c_val[k] = '0;
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [4:0] dest,
                         input logic [4:0] q1, input logic r1, input logic [31:0] v1,
                         input logic [4:0] q2, input logic r2, input logic [31:0] v2);
        issue_valid_in = 1'b1; issue_op_in = op; issue_dest_in = dest;
        issue_q1_in = q1; issue_r1_in = r1; issue_v1_in = v1;
        issue_q2_in = q2; issue_r2_in = r2; issue_v2_in = v2;
    endtask

    function automatic logic [4:0] pick_tag();
        int j = $urandom_range(0, N-1);
        if (m_busy[j] && !m_r1[j]) return m_q1[j];
        if (m_busy[j] && !m_r2[j]) return m_q2[j];
        return 5'($urandom);
    endfunction

    initial begin
        rst_n_in = 1'b0;
        disp_ready_in = 1'b1;
        idle();
        issue(8'h0, 5'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        issue_valid_in = 1'b0;
        #1;
        model_reset();
        check_eq("rst_count", count_out, 0);
        check_eq("rst_full", full_out, 0);
        check_eq("rst_disp_valid", disp_valid_out, 0);
        check_eq("rst_disp_op", disp_op_out, 0);
        check_eq("rst_disp_v1", disp_v1_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Ready-at-issue operands: two edges to disp_valid.
        issue(8'h33, 5'd1, 5'd0, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7);
        step();
        check_eq("lat_not_yet", disp_valid_out, 0);
        idle();
        step();
        check_eq("lat_valid", disp_valid_out, 1);
        check_eq("lat_op", disp_op_out, 8'h33);
        check_eq("lat_v1", disp_v1_out, 5);
        check_eq("lat_v2", disp_v2_out, 7);
        step();

        // Same-cycle issue bypass from channel 1.
        issue(8'h44, 5'd2, 5'd3, 1'b0, 32'd0, 5'd0, 1'b1, 32'h11);
        c_valid[1] = 1'b1; c_tag[1] = 5'd3; c_val[1] = 32'hDEAD;
        step();
        idle();
        step();
        check_eq("byp_valid", disp_valid_out, 1);
        check_eq("byp_v1", disp_v1_out, 32'hDEAD);
        step();

        // Fill all entries, then wake two waiting on tag 9.
        for (int i = 0; i < N; i++) begin
            issue(8'(i), 5'(i), (i == 4 || i == 11) ? 5'd9 : 5'(i + 12), 1'b0, 32'd0,
                  5'd0, 1'b1, 32'(i));
            step();
        end
        check_eq("fill_count", count_out, 16);
        check_eq("fill_full", full_out, 1);
        issue(8'hEE, 5'd30, 5'd31, 1'b0, 32'd0, 5'd0, 1'b1, 32'd0);
        step();
        check_eq("drop_count", count_out, 16);
        idle();
        c_valid[0] = 1'b1; c_tag[0] = 5'd9; c_val[0] = 32'h99;
        step();
        idle();
        step();
        check_eq("wake_a_dest", disp_dest_out, 4);
        check_eq("wake_a_v1", disp_v1_out, 32'h99);
        step();
        check_eq("wake_b_dest", disp_dest_out, 11);
        check_eq("wake_b_count", count_out, 14);
        flush_in = 1'b1;
        step();
        idle();

        // Backpressure with two ready entries.
        disp_ready_in = 1'b0;
        issue(8'h10, 5'd1, 5'd0, 1'b1, 32'hA, 5'd0, 1'b1, 32'hB);
        step();
        issue(8'h20, 5'd2, 5'd0, 1'b1, 32'hC, 5'd0, 1'b1, 32'hD);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_dest", disp_dest_out, 1);
            check_eq("bp_count", count_out, 1);
        end
        disp_ready_in = 1'b1;
        step();
        check_eq("drain_dest", disp_dest_out, 2);
        step();
        check_eq("drain_empty", disp_valid_out, 0);

        // Flush with a loaded dispatch register; concurrent CDB ignored.
        disp_ready_in = 1'b0;
        issue(8'h55, 5'd5, 5'd0, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2);
        step();
        for (int i = 0; i < 5; i++) begin
            issue(8'h60, 5'(6 + i), 5'(20 + i), 1'b0, 32'd0, 5'd0, 1'b1, 32'd0);
            step();
        end
        idle();
        check_eq("pre_flush_count", count_out, 5);
        check_eq("pre_flush_valid", disp_valid_out, 1);
        flush_in = 1'b1;
        issue(8'h70, 5'd12, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0);
        c_valid[0] = 1'b1; c_tag[0] = 5'd20; c_val[0] = 32'h5;
        step();
        check_eq("flush_count", count_out, 0);
        check_eq("flush_valid", disp_valid_out, 0);
        idle();
        step();
        check_eq("post_flush_count", count_out, 0);

        // Asynchronous reset mid-run.
        issue(8'h80, 5'd1, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            issue(8'h81, 5'(2 + i), 5'(10 + i), 1'b0, 32'd0, 5'd0, 1'b1, 32'd0);
            step();
        end
        idle();
        rst_n_in = 1'b0;
        #2;
        check_eq("async_rst_count", count_out, 0);
        check_eq("async_rst_valid", disp_valid_out, 0);
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rdy_in         = ($urandom_range(0, 9) != 0);
            flush_in       = ($urandom_range(0, 59) == 0);
            issue_valid_in = ($urandom_range(0, 2) != 0);
            issue_op_in    = 8'($urandom);
            issue_dest_in  = 5'($urandom);
            issue_q1_in    = 5'($urandom);
            issue_q2_in    = 5'($urandom);
            issue_r1_in    = ($urandom_range(0, 2) == 0);
            issue_r2_in    = ($urandom_range(0, 2) == 0);
            issue_v1_in    = $urandom;
            issue_v2_in    = $urandom;
            disp_ready_in  = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 2; k++) begin
                c_valid[k] = rdy_in && ($urandom_range(0, 1) == 1);
                c_tag[k]   = pick_tag();
                c_val[k]   = $urandom;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
